imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequences a single-port, byte-wide, synchronous-read instruction memory for two requesters.
  - Fetch requester: the core, which reads 32-bit words.
  - Loader requester: the boot/debug path, which writes single bytes.
- Arbitrates round-robin between the two at transaction boundaries.
- Issues four byte reads per fetch and assembles them big-endian: byte at addr in inst[31:24], addr+3 in inst[7:0].
- Supports flush/redirect and flags misaligned or out-of-range fetches.

Parameters:
- ADDR_W, 32, byte address width (matches IM_ADDRESSLEN)
- BYTE_W, 8, memory word width (matches IM_XLEN)
- INST_W, 32, instruction width; must equal 4*BYTE_W (matches IM_INSTLEN)
- MEM_BYTES, 4096, memory depth in bytes (matches IM_SIZE)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request
- req_ready  out  1  fetch request accepted this cycle
- req_addr  in  ADDR_W  fetch byte address
- rsp_valid  out  1  fetch response valid
- rsp_ready  in  1  core accepts response
- rsp_inst  out  INST_W  assembled instruction
- rsp_err  out  1  misaligned or out-of-range fetch
- flush  in  1  abort the current fetch; discard any response
- ld_valid  in  1  loader byte-write request
- ld_ready  out  1  loader write accepted this cycle
- ld_addr  in  ADDR_W  loader byte address
- ld_data  in  BYTE_W  loader byte
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read enable; mem_rdata is valid the cycle after
- mem_rdata  in  BYTE_W  read data
- mem_we  out  1  write enable
- mem_wdata  out  BYTE_W  write data

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - req_ready, ld_ready, rsp_valid, rsp_err, mem_re and mem_we are 0.
  - rsp_inst, mem_addr and mem_wdata are 0.
  - last_grant = LOADER, so fetch wins the first tie.
- State machine: IDLE, ISSUE, DRAIN, RESP.
- IDLE, arbitration:
  - Candidates are req_valid (fetch) and ld_valid (loader), gated by !flush.
  - If both are valid, grant the requester that did not win last; otherwise grant whichever is valid.
  - req_ready and ld_ready are combinational from this decision; at most one is high; both are low outside IDLE.
- Loader grant (cycle T):
  - mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle; the controller stays in IDLE.
  - ld_addr >= MEM_BYTES: the write is suppressed (mem_we=0) but ld_ready is still given.
- Fetch grant (cycle T):
  - Latch the base address; clear the byte counter cnt (2 bits).
  - Error case: base[1:0]!=0 or base+3 >= MEM_BYTES (computed at ADDR_W+1 bits, so no wrap):
    - Go directly to RESP at T+1 with rsp_err=1 and rsp_inst=0.
    - No memory access is made.
  - Normal case: go to ISSUE.
- ISSUE, cycles T+1..T+4:
  - mem_re=1, mem_addr=base+cnt, cnt increments each cycle.
  - Each returned byte is shifted into the assembly register one cycle later.
  - After cnt=3, go to DRAIN.
- DRAIN, cycle T+5: capture the last byte; go to RESP.
- RESP:
  - rsp_valid=1 from T+6; rsp_inst and rsp_err are held stable until rsp_valid and rsp_ready are both high.
  - On that handshake, go to IDLE.
  - A new request can be granted in the cycle after the handshake, so minimum fetch throughput is 1 per 7 cycles.
- Flush:
  - In ISSUE, DRAIN or RESP: go to IDLE next cycle, drop rsp_valid, and ignore the in-flight mem_rdata.
  - Flush during a RESP handshake cycle: the handshake still completes.
  - Flush in IDLE blocks both grants that cycle.
- Reset mid-operation: abort immediately; no response is produced.
- Loader and memory access never overlap a fetch, because grants occur only in IDLE.

Decomposition:
- Shared package riscv_imem_pkg:
  - typedef imem_state_e {IDLE, ISSUE, DRAIN, RESP}
  - typedef grant_e {FETCH, LOADER}
  - localparam BYTES_PER_INST = INST_W/BYTE_W
  - Width constants mirror the IM_* macros in RISCV_defs.svh.
- One natural sub-module: imem_rr_arbiter, the 2-requester round-robin arbiter with a last_grant flop.
- FSM and byte assembly stay in the top.

Test Plan:
- Memory bytes 0x00..0x03 = 13,00,00,93; fetch addr 0 accepted at T -> mem_re T+1..T+4 with addr 0,1,2,3; rsp_valid at T+6 with rsp_inst=0x13000093, rsp_err=0.
- Fetch addr 0x6 -> rsp_err=1, rsp_inst=0 at T+1, no mem_re. Fetch addr MEM_BYTES-2 -> rsp_err=1.
- ld_valid and req_valid high together from reset -> fetch granted first; the loader is granted in the cycle after the fetch handshake; next tie -> fetch again.
- Loader writes 0xAB to addr 8, then fetch addr 8 -> mem_we pulse with addr 8 / data 0xAB; fetch returns inst[31:24]=0xAB.
- flush asserted at T+3 -> IDLE at T+4, mem_re low from T+4, rsp_valid never rises; a new fetch at addr 4 returns the correct word.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_inst stable throughout; req_ready=0; an rst_n pulse mid-ISSUE -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_imem_pkg.sv
// Shared types and width constants for the instruction-memory fetch path.
package riscv_imem_pkg;

  // Width constants mirror the IM_* macros in RISCV_defs.svh
  localparam int IM_ADDRESSLEN  = 32;
  localparam int IM_XLEN        = 8;
  localparam int IM_INSTLEN     = 32;
  localparam int IM_SIZE        = 4096;
  localparam int BYTES_PER_INST = IM_INSTLEN / IM_XLEN;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} imem_state_e;
  typedef enum logic {FETCH, LOADER} grant_e;

endpackage

// File: rtl/imem_fetch_ctrl_rr_arbiter.sv
// Two-requester round-robin arbiter: on a tie, the requester that did not win
// last time is granted. The last_grant history resets to LOADER so that fetch
// wins the first tie.
module imem_rr_arbiter
  import riscv_imem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_fetch,
  input  logic req_ld,
  output logic gnt_fetch,
  output logic gnt_ld
);

  grant_e last_q;

  // Grant decision is purely combinational from the requests and the history
  always_comb begin
    gnt_fetch = req_fetch && (!req_ld || (last_q == LOADER));
    gnt_ld    = req_ld && (!req_fetch || (last_q == FETCH));
  end

  // Remember who won most recently; unchanged when nobody is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LOADER;
    end else if (gnt_fetch) begin
      last_q <= FETCH;
    end else if (gnt_ld) begin
      last_q <= LOADER;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: arbitrates the core's 32-bit fetches against
// single-byte loader writes on a byte-wide synchronous-read memory, reads four
// bytes per fetch and assembles them big-endian.
module imem_fetch_ctrl
  import riscv_imem_pkg::*;
#(
  parameter int ADDR_W    = IM_ADDRESSLEN,
  parameter int BYTE_W    = IM_XLEN,
  parameter int INST_W    = IM_INSTLEN,
  parameter int MEM_BYTES = IM_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [INST_W-1:0] rsp_inst,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BYTE_W-1:0] ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata
);

  // Limits are compared at ADDR_W+1 bits so base+3 cannot wrap past zero
  localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [1:0]      CNT_LAST = 2'(BYTES_PER_INST - 1);

  imem_state_e       state_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        cnt_q;
  logic              vld_p1;
  logic [INST_W-1:0] asm_q;
  logic [INST_W-1:0] asm_next;
  logic              arb_en;
  logic              gnt_fetch;
  logic              gnt_ld;
  logic              ld_in_range;
  logic              capture;

  function automatic logic fetch_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] last_byte;
    last_byte = {1'b0, a} + (ADDR_W+1)'(BYTES_PER_INST - 1);
    return (a[1:0] != 2'b00) || (last_byte >= MEM_LIM);
  endfunction

  // Grants only happen in IDLE, outside reset, and never while flushing
  assign arb_en      = rst_n && (state_q == IDLE) && !flush;
  assign req_ready   = gnt_fetch;
  assign ld_ready    = gnt_ld;
  assign rsp_valid   = (state_q == RESP);
  assign ld_in_range = ({1'b0, ld_addr} < MEM_LIM);
  assign asm_next    = {asm_q[INST_W-BYTE_W-1:0], mem_rdata};
  assign capture     = vld_p1 && !flush && ((state_q == ISSUE) || (state_q == DRAIN));

  imem_rr_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_fetch (req_valid && arb_en),
    .req_ld    (ld_valid && arb_en),
    .gnt_fetch (gnt_fetch),
    .gnt_ld    (gnt_ld)
  );

  // Memory port: byte reads while issuing, same-cycle byte write on a loader grant
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ISSUE) begin
      mem_re   = 1'b1;
      mem_addr = base_q + ADDR_W'(cnt_q);
    end else if (gnt_ld) begin
      mem_we    = ld_in_range;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end
  end

  // Control FSM: byte counter, read-in-flight tag and the response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vld_p1   <= 1'b0;
      rsp_inst <= '0;
      rsp_err  <= 1'b0;
    end else begin
      vld_p1 <= mem_re && !flush;
      case (state_q)
        IDLE: begin
          if (gnt_fetch) begin
            cnt_q <= '0;
            if (fetch_err(req_addr)) begin
              state_q  <= RESP;
              rsp_err  <= 1'b1;
              rsp_inst <= '0;
            end else begin
              state_q <= ISSUE;
              rsp_err <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == CNT_LAST) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            rsp_inst <= asm_next;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (flush || rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: latch the fetch base and shift returned bytes in, oldest at the top
  always_ff @(posedge clk) begin
    if (gnt_fetch) base_q <= req_addr;
    if (capture)   asm_q  <= asm_next;
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: byte memory model plus a reference copy of the
// memory contents from which expected instructions are computed.
module tb_imem_fetch_ctrl;

  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush;
  logic [31:0] req_addr, rsp_inst, ld_addr, mem_addr;
  logic        ld_valid, ld_ready, mem_re, mem_we;
  logic [7:0]  ld_data, mem_rdata, mem_wdata;

  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  bit          mem_init = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  imem_fetch_ctrl #(.ADDR_W(32), .BYTE_W(8), .INST_W(32), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 5));
  endfunction

  // Synchronous-read byte memory; rdata is noise when no read was issued
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_we && mem_addr < MEM_BYTES) mem[mem_addr[11:0]] <= mem_wdata;
      if (mem_re && mem_addr < MEM_BYTES) mem_rdata <= mem[mem_addr[11:0]];
      else mem_rdata <= 8'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [31:0] a, input logic [7:0] d);
    bit inr;
    inr = (longint'(a) < MEM_BYTES);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    check("ld_grant", ld_ready, 1);
    check("ld_req_rdy", req_ready, 0);
    check("ld_we", mem_we, inr);
    check("ld_waddr", mem_addr, a);
    check("ld_wdata", mem_wdata, d);
    if (inr) ref_mem[int'(a)] = d;
    tick();
    ld_valid = 1'b0;
  endtask

  // fl: 0 none, 1..5 flush in that cycle after grant (ISSUE/DRAIN), 6 flush in first RESP cycle
  task automatic fetch(input logic [31:0] a, input int hold, input int fl, input bit keep);
    logic        exp_err;
    logic [31:0] exp_inst;
    int          w;
    bit          done;
    exp_err  = (a % 4 != 0) || (longint'(a) + 3 >= MEM_BYTES);
    exp_inst = exp_err ? 32'h0 :
               {ref_mem[int'(a)], ref_mem[int'(a)+1], ref_mem[int'(a)+2], ref_mem[int'(a)+3]};
    req_valid = 1'b1; req_addr = a;
    #1;
    w = 0;
    while (!req_ready && w < 20) begin tick(); #1; w++; end
    check("fetch_grant", req_ready, 1);
    check("fetch_ld_rdy", ld_ready, 0);
    check("fetch_we", mem_we, 0);
    if (!exp_err) begin
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (c == fl) flush = 1'b1;
        #1;
        check("issue_re", mem_re, (c <= 4));
        if (c <= 4) check("issue_addr", mem_addr, a + c - 1);
        check("issue_vld", rsp_valid, 0);
        check("issue_rdy", req_ready, 0);
        check("issue_ld_rdy", ld_ready, 0);
        if (c == fl) begin
          tick();
          flush = 1'b0; req_valid = 1'b0;
          for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            #1;
            check("flush_re", mem_re, 0);
            check("flush_vld", rsp_valid, 0);
          end
          return;
        end
      end
    end
    done = 1'b0;
    for (int h = 0; h <= hold && !done; h++) begin
      tick();
      rsp_ready = (h == hold);
      if (fl == 6 && h == 0) flush = 1'b1;
      #1;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_inst", rsp_inst, exp_inst);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_re", mem_re, 0);
      check("rsp_rdy", req_ready, 0);
      if (flush) done = 1'b1;
    end
    tick();
    rsp_ready = 1'b0; flush = 1'b0;
    if (!keep) req_valid = 1'b0;
    #1;
    check("vld_drop", rsp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          sel, fl;
    rst_n = 1'b0; req_valid = 1'b1; ld_valid = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    req_addr = 32'h0; ld_addr = 32'h20; ld_data = 8'h55;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with both requesters asserting
    check("rst_req_rdy", req_ready, 0);
    check("rst_ld_rdy", ld_ready, 0);
    check("rst_vld", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_inst", rsp_inst, 0);
    check("rst_re", mem_re, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    req_valid = 1'b0; ld_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Directed cases
    ld_write(0, 8'h13); ld_write(1, 8'h00); ld_write(2, 8'h00); ld_write(3, 8'h93);
    fetch(0, 0, 0, 0);
    check("plan_word", {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]}, 32'h13000093);
    fetch(6, 0, 0, 0);
    fetch(MEM_BYTES - 2, 0, 0, 0);
    fetch(MEM_BYTES - 4, 0, 0, 0);
    ld_write(8, 8'hAB);
    fetch(8, 0, 0, 0);
    fetch(4, 0, 3, 0);
    fetch(4, 0, 0, 0);
    fetch(12, 5, 0, 0);
    fetch(16, 2, 6, 0);
    fetch(5, 3, 0, 0);
    ld_write(MEM_BYTES, 8'h77);
    ld_write(32'hFFFF_FFFF, 8'h66);
    fetch(32'hFFFF_FFFC, 0, 0, 0);

    // Flush in IDLE blocks both grants
    req_valid = 1'b1; ld_valid = 1'b1; flush = 1'b1; req_addr = 0; ld_addr = 40;
    #1;
    check("idle_flush_req", req_ready, 0);
    check("idle_flush_ld", ld_ready, 0);
    check("idle_flush_we", mem_we, 0);
    tick();
    req_valid = 1'b0; ld_valid = 1'b0; flush = 1'b0;

    // Reset pulse in the middle of ISSUE
    req_valid = 1'b1; req_addr = 0;
    #1;
    check("mid_grant", req_ready, 1);
    tick(); req_valid = 1'b0;
    tick();
    #1;
    check("mid_issue_re", mem_re, 1);
    rst_n = 1'b0; req_valid = 1'b1; ld_valid = 1'b1;
    #1;
    check("mid_rst_re", mem_re, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_vld", rsp_valid, 0);
    check("mid_rst_req_rdy", req_ready, 0);
    check("mid_rst_ld_rdy", ld_ready, 0);
    check("mid_rst_we", mem_we, 0);
    tick();
    req_valid = 1'b0; ld_valid = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("post_rst_vld", rsp_valid, 0);
      check("post_rst_re", mem_re, 0);
    end

    // Round-robin: tie after reset goes to fetch, then loader, then fetch
    ld_valid = 1'b1; ld_addr = 16; ld_data = 8'h5A;
    fetch(0, 0, 0, 1);
    check("rr_ld_rdy", ld_ready, 1);
    check("rr_req_rdy", req_ready, 0);
    check("rr_we", mem_we, 1);
    check("rr_waddr", mem_addr, 16);
    check("rr_wdata", mem_wdata, 8'h5A);
    ref_mem[16] = 8'h5A;
    tick();
    ld_addr = 20; ld_data = 8'hC3;
    fetch(16, 1, 0, 0);
    check("rr_ld_after", ld_ready, 1);
    check("rr_we_after", mem_we, 1);
    ref_mem[20] = 8'hC3;
    tick();
    ld_valid = 1'b0;
    fetch(20, 0, 0, 0);

    // Randomized mix of loader writes and fetches
    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        if ($urandom_range(0, 4) == 0) a = MEM_BYTES + $urandom_range(0, 100);
        else a = $urandom_range(0, 63);
        ld_write(a, 8'($urandom));
      end else begin
        sel = $urandom_range(0, 9);
        if (sel < 6)      a = $urandom_range(0, 15) * 4;
        else if (sel < 8) a = $urandom_range(0, 63) | 32'h1;
        else              a = MEM_BYTES - $urandom_range(1, 8);
        fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
        fetch(a, $urandom_range(0, 3), fl, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
